// File: rtl/block_signed_norm.sv
// Block-floating-point normalizer: buffers N signed samples, then replays
// them left-shifted by the block's common redundant-sign count.
module block_signed_norm #(
  parameter int W         = 24,
  parameter int N         = 16,
  parameter int SHIFT_MAX = W - 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [5:0]   out_shift,
  output logic         out_first,
  output logic         out_last
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [5:0] SMAX = 6'(SHIFT_MAX);
  localparam logic [5:0] RCAP = 6'(W - 2);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    smp_mem [N];
  logic [CW-1:0]   wr_cnt, rd_cnt;
  logic [5:0]      min_q, shift_q;
  logic            nz_q, byp_q;

  function automatic logic [5:0] rsc(input logic [W-1:0] x);
    logic [5:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = W - 2; i >= 0; i--) begin
      if (run && (x[i] == x[W-1])) n = n + 6'd1;
      else run = 1'b0;
    end
    if (n > RCAP) n = RCAP;
    return n;
  endfunction

  logic       acc, xfer, first_in, last_in, last_out;
  logic       nz_in, nz_cur, nz_nx, byp_cur;
  logic [5:0] r_in, min_cur, min_nx, shift_nx;

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == DRAIN);
  assign acc       = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign first_in  = (wr_cnt == '0);
  assign last_in   = (wr_cnt == LAST_IDX);
  assign last_out  = (rd_cnt == LAST_IDX);

  // Running minimum folds in each sample as it arrives; 6'h3F = none yet.
  always_comb begin
    r_in    = rsc(in_data);
    nz_in   = |in_data;
    min_cur = first_in ? 6'h3F : min_q;
    nz_cur  = first_in ? 1'b0 : nz_q;
    byp_cur = first_in ? bypass : byp_q;
    min_nx  = (nz_in && (r_in < min_cur)) ? r_in : min_cur;
    nz_nx   = nz_cur | nz_in;
    if (byp_cur || !nz_nx) shift_nx = '0;
    else shift_nx = (min_nx > SMAX) ? SMAX : min_nx;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:  if (acc && last_in) state_d = DRAIN;
      DRAIN: if (xfer && last_out) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      min_q   <= 6'h3F;
      nz_q    <= 1'b0;
      byp_q   <= 1'b0;
      shift_q <= '0;
    end else begin
      if (acc) begin
        wr_cnt <= last_in ? '0 : wr_cnt + 1'b1;
        min_q  <= min_nx;
        nz_q   <= nz_nx;
        byp_q  <= byp_cur;
        if (last_in) shift_q <= shift_nx;
      end
      if (xfer) begin
        rd_cnt <= last_out ? '0 : rd_cnt + 1'b1;
        if (last_out) begin
          min_q <= 6'h3F;
          nz_q  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) smp_mem[wr_cnt] <= in_data;
  end

  // Outputs are gated so stale buffer contents never leak out of FILL.
  always_comb begin
    out_data  = '0;
    out_shift = '0;
    out_first = 1'b0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data  = smp_mem[rd_cnt] << shift_q;
      out_shift = shift_q;
      out_first = (rd_cnt == '0);
      out_last  = last_out;
    end
  end

endmodule

// File: tb/tb_block_signed_norm.sv
// Bench for block_signed_norm: directed vectors plus random blocks
// against an arithmetic model of the block shift.
module tb_block_signed_norm;

  localparam int W = 24;
  localparam int N = 4;
  localparam int SMAX = W - 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         bypass;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [5:0]   out_shift;
  logic         out_first;
  logic         out_last;

  int total = 0;
  int bad = 0;

  block_signed_norm #(.W(W), .N(N), .SHIFT_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bypass(bypass),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_shift(out_shift),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Largest s such that x*2^s still fits a W-bit signed range.
  function automatic int model_r(input logic [W-1:0] x);
    longint v, p, lo, hi;
    v  = longint'($signed(x));
    lo = -(longint'(1) <<< (W - 1));
    hi = (longint'(1) <<< (W - 1)) - 1;
    if (v == 0) return -1;
    for (int s = W - 2; s >= 0; s--) begin
      p = v * (longint'(1) <<< s);
      if (p >= lo && p <= hi) return s;
    end
    return 0;
  endfunction

  function automatic int model_s(input logic [W-1:0] s[N], input bit byp);
    int m;
    m = 1000;
    for (int i = 0; i < N; i++)
      if (model_r(s[i]) >= 0 && model_r(s[i]) < m) m = model_r(s[i]);
    if (byp || m == 1000) return 0;
    return (m > SMAX) ? SMAX : m;
  endfunction

  task automatic fill(input logic [W-1:0] s[N], input bit byp, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      in_valid = 1'b1;
      in_data  = s[i];
      bypass   = (i == 0) ? byp : 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("in_ready_fill", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: 3-cycle stall on output 1
  task automatic run_block(input logic [W-1:0] s[N], input bit byp,
                           input int mode, input bit junk,
                           input int exp_s_fixed);
    logic [W-1:0] e [N];
    int es, idx, cyc, stalls;
    es = model_s(s, byp);
    if (exp_s_fixed >= 0) chk("model_s", es, exp_s_fixed);
    for (int i = 0; i < N; i++)
      e[i] = W'(longint'($signed(s[i])) * (longint'(1) <<< es));
    fill(s, byp, N);
    in_valid = junk;
    in_data  = W'($urandom);
    bypass   = 1'($urandom_range(0, 1));
    idx = 0; cyc = 0; stalls = 0;
    while (idx < N && cyc < 60) begin
      if (mode == 2) out_ready = !(idx == 1 && stalls < 3);
      else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
      @(negedge clk);
      if (cyc == 0) chk("latency", out_valid, 1);
      if (out_valid) begin
        chk("in_ready_drain", in_ready, 0);
        if (out_ready) begin
          chk("data", out_data, e[idx]);
          chk("shift", out_shift, es);
          chk("first", out_first, idx == 0);
          chk("last", out_last, idx == N - 1);
          idx++;
        end else begin
          chk("hold", out_data, e[idx]);
          stalls++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (idx < N) chk("drain_timeout", idx, N);
    if (mode == 2) chk("stall_cnt", stalls, 3);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after", in_ready, 1);
    chk("valid_after", out_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outs();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_shift", out_shift, 0);
    chk("rst_first", out_first, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ready", in_ready, 1);
  endtask

  logic [W-1:0] blk [N];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; bypass = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs();
    rst = 1'b0;
    @(posedge clk); #1;

    blk = '{24'h000010, 24'h000100, 24'hFFFF00, 24'h000001};
    run_block(blk, 1'b0, 0, 1'b0, 14);
    blk = '{24'h0, 24'h0, 24'h0, 24'h0};
    run_block(blk, 1'b0, 0, 1'b1, 0);
    blk = '{24'h7FFFFF, 24'h000001, 24'h000002, 24'h000003};
    run_block(blk, 1'b0, 0, 1'b0, 0);
    blk = '{24'h000010, 24'h000100, 24'hFFFF00, 24'h000001};
    run_block(blk, 1'b0, 2, 1'b1, 14);
    run_block(blk, 1'b1, 0, 1'b0, 0);

    blk = '{24'h000123, 24'h000456, 24'h0, 24'h0};
    fill(blk, 1'b0, 2);
    rst = 1'b1; #1;
    chk_reset_outs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    blk = '{24'h000001, 24'h000002, 24'h000004, 24'h000008};
    run_block(blk, 1'b0, 0, 1'b0, 19);

    blk = '{24'h000001, 24'h000002, 24'h000004, 24'h000008};
    fill(blk, 1'b0, N);
    @(negedge clk);
    chk("pend_valid", out_valid, 1);
    rst = 1'b1; #1;
    chk_reset_outs();
    @(posedge clk); #1;
    rst = 1'b0;
    blk = '{24'hFFFFFF, 24'h000000, 24'h000003, 24'hFFFFFC};
    run_block(blk, 1'b0, 1, 1'b1, 21);

    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: blk[i] = '0;
          1: blk[i] = W'($urandom);
          default: blk[i] = W'($signed(W'($urandom)) >>> $urandom_range(0, W - 1));
        endcase
      end
      run_block(blk, ($urandom_range(0, 4) == 0), 1, 1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/block_signed_norm.md
BLOCK_SIGNED_NORM -- requirements
Module: block_signed_norm

Interface
REQ-001 Parameter W, default 24: sample width, two's complement, W in 4..32.
REQ-002 Parameter N, default 16: samples per block, N >= 2.
REQ-003 Parameter SHIFT_MAX, default W-2: upper limit on the block shift, 0..W-2.
REQ-004 clk  input  1  single clock; every register updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block accepts a sample.
REQ-008 in_data  input  W  signed input sample.
REQ-009 bypass  input  1  forces shift 0 for the block; sampled with the block's first sample.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  downstream accepts a sample.
REQ-012 out_data  output  W  normalized sample.
REQ-013 out_shift  output  6  block shift applied to out_data.
REQ-014 out_first / out_last  output  1 each  flag the first / last sample of a block.

Function
REQ-015 Handshake rules:
- A transfer occurs when valid=1 and ready=1 on the same rising edge.
- out_data, out_shift, out_first and out_last shall hold stable while out_valid=1 and out_ready=0.
REQ-016 State machine has two states:
- FILL: in_ready=1, out_valid=0.
- DRAIN: in_ready=0, out_valid=1.
- Reset enters FILL.
REQ-017 In FILL, each accepted sample is written to a buffer at index wr_cnt, and wr_cnt increments.
REQ-018 On acceptance of the N-th sample:
- wr_cnt wraps to 0.
- The block shift is latched.
- The state moves to DRAIN.
- out_valid asserts on the next rising edge (latency 1 cycle from last input to first output).
REQ-019 Redundant sign count r(x) of a nonzero x is the number of consecutive bits from x[W-2] downward equal to x[W-1], capped at W-2.
- x=0 contributes no count.
- Examples, W=24: r(1)=22, r(-1)=22, r(0x7FFFFF)=0.
REQ-020 Block shift value:
- S = min(min over nonzero samples of r, SHIFT_MAX).
- S = 0 if all samples are zero, or if bypass was 1 at the first sample.
REQ-021 The running minimum shall be updated per accepted sample, so that no extra pass over the buffer is needed.
REQ-022 In DRAIN:
- out_data = buffer[rd_cnt] shifted left by S, low bits zero-filled, truncated to W bits.
- out_shift = S.
- rd_cnt increments on each output transfer.
REQ-023 out_first=1 only when rd_cnt=0; out_last=1 only when rd_cnt=N-1.
REQ-024 Block end:
- The output transfer with out_last=1 returns the state to FILL and clears rd_cnt and the running minimum.
- in_ready asserts on the following cycle.
REQ-025 in_valid asserted during DRAIN shall be ignored, with no side effects.
REQ-026 bypass is ignored for samples other than the first of a block.
REQ-027 Normalization never overflows: S <= the minimum r, so the sign of every output equals the sign of its input.

Reset
REQ-028 On rst=1, immediately and asynchronously:
- State = FILL.
- wr_cnt = 0, rd_cnt = 0, running minimum cleared.
- out_valid=0, out_data=0, out_shift=0, out_first=0, out_last=0.
REQ-029 Reset mid-block (in FILL or DRAIN) discards the partial or pending block. The first sample accepted after rst deasserts starts a new block.
REQ-030 Buffer contents need no reset; they shall never be observable before being written.

Verification
REQ-031 Normal block, W=24, N=4, bypass=0:
- Stimulus: 0x000010, 0x000100, 0xFFFF00, 0x000001.
- Response: S=14; outputs 0x040000, 0x400000, 0xC00000, 0x004000; out_first on the first output, out_last on the fourth.
REQ-032 All-zero block (four samples of 0):
- Response: S=0, four outputs of 0x000000.
REQ-033 Full-scale sample:
- Stimulus: block 0x7FFFFF, 0x000001, 0x000002, 0x000003.
- Response: S=0, outputs identical to inputs.
REQ-034 Backpressure:
- Stimulus: REQ-031 stimulus with out_ready=0 for 3 cycles while the second output is presented.
- Response: out_data held at 0x400000, no sample lost or duplicated, in_ready=0 throughout DRAIN.
REQ-035 Bypass:
- Stimulus: REQ-031 stimulus with bypass=1 on the first sample only.
- Response: S=0, outputs equal inputs.
REQ-036 Reset mid-block:
- Stimulus: rst pulse after 2 accepted samples, then samples 0x000001, 0x000002, 0x000004, 0x000008.
- Response: all outputs 0 during reset; new block S=19; outputs 0x080000, 0x100000, 0x200000, 0x400000.
